// File: rtl/uart_line_editor.sv
// Line editor between uart_rx and the command consumer: keeps an editable line buffer, echoes
// terminal feedback one byte per cycle, and streams completed lines out over valid/ready.
module uart_line_editor #(
  parameter int unsigned LINE_MAX = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_valid_i,
  output logic [7:0] echo_data_o,
  output logic       echo_valid_o,
  output logic [7:0] line_data_o,
  output logic       line_valid_o,
  output logic       line_last_o,
  input  logic       line_ready_i,
  output logic [6:0] line_len_o,
  output logic       rx_dropped_o
);

  localparam int unsigned IdxW   = $clog2(LINE_MAX);
  localparam logic [6:0]  LenMax = 7'(LINE_MAX);

  typedef enum logic [1:0] {StEdit, StEcho, StDrain} state_e;

  state_e          state_q, state_d;
  logic [7:0]      line_buf_q [LINE_MAX];
  logic [6:0]      len_q, len_d;
  logic [6:0]      rd_idx_q, rd_idx_d;
  logic [2:0][7:0] echo_seq_q, echo_seq_d;
  logic [1:0]      echo_idx_q, echo_idx_d;
  logic [1:0]      echo_last_q, echo_last_d;
  logic            drain_pend_q, drain_pend_d;
  logic            skid_valid_q, skid_valid_d;
  logic [7:0]      skid_byte_q, skid_byte_d;
  logic            dropped_q, dropped_d;

  logic       proc_valid;
  logic [7:0] cur_byte;
  logic       is_print, is_bs, is_cr;
  logic       len_zero, len_full;
  logic       start_echo, echo_done, drain_xfer, drain_done, buf_we;

  // A pending skid byte always takes priority over a fresh arrival in EDIT.
  always_comb begin
    proc_valid = 1'b0;
    cur_byte   = rx_byte_i;
    if (state_q == StEdit) begin
      if (skid_valid_q) begin
        proc_valid = 1'b1;
        cur_byte   = skid_byte_q;
      end else if (rx_valid_i) begin
        proc_valid = 1'b1;
      end
    end
  end

  assign is_print   = (cur_byte >= 8'h20) && (cur_byte <= 8'h7e);
  assign is_bs      = (cur_byte == 8'h08) || (cur_byte == 8'h7f);
  assign is_cr      = (cur_byte == 8'h0d);
  assign len_zero   = (len_q == 7'd0);
  assign len_full   = (len_q >= LenMax);
  assign start_echo = proc_valid && (is_print || is_cr || (is_bs && !len_zero));
  assign echo_done  = (state_q == StEcho) && (echo_idx_q == echo_last_q);
  assign drain_xfer = (state_q == StDrain) && line_ready_i;
  assign drain_done = drain_xfer && (rd_idx_q == len_q - 7'd1);
  assign buf_we     = proc_valid && is_print && !len_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEdit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEdit:  if (start_echo) state_d = StEcho;
      StEcho:  if (echo_done) state_d = drain_pend_q ? StDrain : StEdit;
      StDrain: if (drain_done) state_d = StEdit;
      default: state_d = StEdit;
    endcase
  end

  always_comb begin
    len_d        = len_q;
    rd_idx_d     = rd_idx_q;
    echo_seq_d   = echo_seq_q;
    echo_idx_d   = echo_idx_q;
    echo_last_d  = echo_last_q;
    drain_pend_d = drain_pend_q;
    skid_valid_d = skid_valid_q;
    skid_byte_d  = skid_byte_q;
    dropped_d    = 1'b0;
    unique case (state_q)
      StEdit: begin
        if (skid_valid_q) begin
          skid_valid_d = rx_valid_i;
          skid_byte_d  = rx_byte_i;
        end
        if (start_echo) begin
          echo_idx_d   = 2'd0;
          drain_pend_d = 1'b0;
          if (is_print) begin
            echo_seq_d  = {16'h0000, (len_full ? 8'h07 : cur_byte)};
            echo_last_d = 2'd0;
            if (!len_full) len_d = len_q + 7'd1;
          end else if (is_bs) begin
            echo_seq_d  = {8'h08, 8'h20, 8'h08};
            echo_last_d = 2'd2;
            len_d       = len_q - 7'd1;
          end else begin
            echo_seq_d   = {8'h00, 8'h0a, 8'h0d};
            echo_last_d  = 2'd1;
            drain_pend_d = !len_zero;
          end
        end
      end
      StEcho: begin
        if (rx_valid_i) begin
          if (skid_valid_q) begin
            dropped_d = 1'b1;
          end else begin
            skid_valid_d = 1'b1;
            skid_byte_d  = rx_byte_i;
          end
        end
        if (echo_done) begin
          rd_idx_d = 7'd0;
        end else begin
          echo_idx_d = echo_idx_q + 2'd1;
        end
      end
      StDrain: begin
        // The skid byte is kept across the drain and handled once editing resumes.
        dropped_d = rx_valid_i;
        if (drain_xfer) begin
          if (drain_done) begin
            len_d = 7'd0;
          end else begin
            rd_idx_d = rd_idx_q + 7'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q        <= 7'd0;
      rd_idx_q     <= 7'd0;
      echo_seq_q   <= '0;
      echo_idx_q   <= 2'd0;
      echo_last_q  <= 2'd0;
      drain_pend_q <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_byte_q  <= 8'h00;
      dropped_q    <= 1'b0;
    end else begin
      len_q        <= len_d;
      rd_idx_q     <= rd_idx_d;
      echo_seq_q   <= echo_seq_d;
      echo_idx_q   <= echo_idx_d;
      echo_last_q  <= echo_last_d;
      drain_pend_q <= drain_pend_d;
      skid_valid_q <= skid_valid_d;
      skid_byte_q  <= skid_byte_d;
      dropped_q    <= dropped_d;
    end
  end

  // Contents beyond len_q are never observed, so the buffer needs no reset.
  always_ff @(posedge clk_i) begin
    if (buf_we) line_buf_q[len_q[IdxW-1:0]] <= cur_byte;
  end

  always_comb begin
    echo_valid_o = 1'b0;
    echo_data_o  = 8'h00;
    line_valid_o = 1'b0;
    line_data_o  = 8'h00;
    line_last_o  = 1'b0;
    if (state_q == StEcho) begin
      echo_valid_o = 1'b1;
      echo_data_o  = echo_seq_q[echo_idx_q];
    end
    if (state_q == StDrain) begin
      line_valid_o = 1'b1;
      line_data_o  = line_buf_q[rd_idx_q[IdxW-1:0]];
      line_last_o  = (rd_idx_q == len_q - 7'd1);
    end
  end

  assign line_len_o   = len_q;
  assign rx_dropped_o = dropped_q;

endmodule

// File: tb/tb_uart_line_editor.sv
// Bench for uart_line_editor: a timestamped reference model feeds expected echo, line and drop
// events into queues that an independent monitor checks against the DUT.
module tb_uart_line_editor;

  localparam int unsigned LINE_MAX = 8;
  localparam int          NEVER    = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] echo_data;
  logic       echo_valid;
  logic [7:0] line_data;
  logic       line_valid;
  logic       line_last;
  logic       line_ready;
  logic [6:0] line_len;
  logic       rx_dropped;

  uart_line_editor #(.LINE_MAX(LINE_MAX)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_byte_i    (rx_byte),
    .rx_valid_i   (rx_valid),
    .echo_data_o  (echo_data),
    .echo_valid_o (echo_valid),
    .line_data_o  (line_data),
    .line_valid_o (line_valid),
    .line_last_o  (line_last),
    .line_ready_i (line_ready),
    .line_len_o   (line_len),
    .rx_dropped_o (rx_dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } echo_t;

  echo_t      echo_q[$];
  logic [8:0] line_q[$];
  int         drop_q[$];
  bit         mon_en = 1'b0;

  // Reference model: line contents, one-byte holding slot, and when the editor is next free.
  logic [7:0] m_line[$];
  bit         m_skid_v;
  logic [7:0] m_skid;
  int         m_free_at;
  bit         m_drain;
  int         m_drain_start;
  int         m_rem;

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(string name, int act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
  endfunction

  function automatic void model_reset();
    m_line.delete();
    m_skid_v  = 1'b0;
    m_skid    = 8'h00;
    m_free_at = 0;
    m_drain   = 1'b0;
    m_rem     = 0;
    echo_q.delete();
    line_q.delete();
    drop_q.delete();
  endfunction

  function automatic void push_echo(int t, logic [7:0] d);
    echo_t e;
    e.cyc  = t;
    e.data = d;
    echo_q.push_back(e);
  endfunction

  function automatic void process(logic [7:0] b, int s);
    int n;
    n = m_line.size();
    if (b >= 8'h20 && b <= 8'h7e) begin
      if (n < int'(LINE_MAX)) begin
        m_line.push_back(b);
        push_echo(s + 1, b);
      end else begin
        push_echo(s + 1, 8'h07);
      end
      m_free_at = s + 2;
    end else if (b == 8'h08 || b == 8'h7f) begin
      if (n > 0) begin
        void'(m_line.pop_back());
        push_echo(s + 1, 8'h08);
        push_echo(s + 2, 8'h20);
        push_echo(s + 3, 8'h08);
        m_free_at = s + 4;
      end
    end else if (b == 8'h0d) begin
      push_echo(s + 1, 8'h0d);
      push_echo(s + 2, 8'h0a);
      m_free_at = s + 3;
      if (n > 0) begin
        for (int i = 0; i < n; i++) line_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, m_line[i]});
        m_drain       = 1'b1;
        m_drain_start = s + 3;
        m_rem         = n;
        m_free_at     = NEVER;
      end
    end
  endfunction

  function automatic void model_cycle(int s, bit v, logic [7:0] b, bit r);
    if (m_drain && s >= m_drain_start) begin
      if (v) drop_q.push_back(s + 1);
      if (r) begin
        m_rem--;
        if (m_rem == 0) begin
          m_drain   = 1'b0;
          m_line.delete();
          m_free_at = s + 1;
        end
      end
    end else if (s < m_free_at) begin
      if (v) begin
        if (!m_skid_v) begin
          m_skid_v = 1'b1;
          m_skid   = b;
        end else begin
          drop_q.push_back(s + 1);
        end
      end
    end else if (m_skid_v) begin
      process(m_skid, s);
      m_skid_v = v;
      m_skid   = b;
    end else if (v) begin
      process(b, s);
    end
  endfunction

  // Monitor: pops expectations as the DUT presents outputs; stale entries count as missing.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      while (echo_q.size() > 0 && echo_q[0].cyc < cyc) begin
        check("echo_missing", cyc, echo_q[0].cyc);
        void'(echo_q.pop_front());
      end
      if (echo_valid) begin
        if (echo_q.size() == 0) begin
          flag("echo_extra", echo_data);
        end else begin
          check("echo_data", echo_data, echo_q[0].data);
          check("echo_cycle", cyc, echo_q[0].cyc);
          void'(echo_q.pop_front());
        end
      end
      if (line_valid) begin
        if (line_q.size() == 0) begin
          flag("line_extra", {line_last, line_data});
        end else begin
          check("line_last_data", {line_last, line_data}, line_q[0]);
          if (line_ready) void'(line_q.pop_front());
        end
      end
      while (drop_q.size() > 0 && drop_q[0] < cyc) begin
        check("drop_missing", cyc, drop_q[0]);
        void'(drop_q.pop_front());
      end
      if (rx_dropped) begin
        if (drop_q.size() == 0) begin
          flag("drop_extra", 1);
        end else begin
          check("drop_cycle", cyc, drop_q[0]);
          void'(drop_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] b, input bit r);
    check("line_len", line_len, m_line.size());
    rx_valid   = v;
    rx_byte    = b;
    line_ready = r;
    model_cycle(cyc, v, b, r);
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input int gap, input bit r);
    step(1'b1, b, r);
    repeat (gap) step(1'b0, 8'h00, r);
  endtask

  task automatic send_str(input string s, input int gap, input bit r);
    for (int i = 0; i < s.len(); i++) put(s[i], gap, r);
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) step(1'b0, 8'h00, r);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_echo_valid"}, echo_valid, 0);
    check({tag, "_echo_data"}, echo_data, 0);
    check({tag, "_line_valid"}, line_valid, 0);
    check({tag, "_line_data"}, line_data, 0);
    check({tag, "_line_last"}, line_last, 0);
    check({tag, "_line_len"}, line_len, 0);
    check({tag, "_rx_dropped"}, rx_dropped, 0);
  endtask

  initial begin
    int dens;
    int pick;
    logic [7:0] b;
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = 8'h00;
    line_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    send_str("AB", 5, 1'b1);
    put(8'h0d, 8, 1'b1);
    send_str("AC", 5, 1'b1);
    put(8'h08, 5, 1'b1);
    send_str("D", 5, 1'b1);
    put(8'h0d, 10, 1'b1);
    send_str("ABCDEFGHI", 3, 1'b1);
    put(8'h0d, 14, 1'b1);
    put(8'h08, 3, 1'b1);
    put(8'h0d, 5, 1'b1);
    send_str("X", 3, 1'b0);
    put(8'h0d, 2, 1'b0);
    step(1'b1, 8'h59, 1'b0);
    idle(10, 1'b0);
    idle(6, 1'b1);
    step(1'b1, 8'h51, 1'b1);
    step(1'b1, 8'h52, 1'b1);
    idle(6, 1'b1);
    put(8'h0a, 2, 1'b1);

    dens = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) dens = (dens == 30) ? 90 : 30;
      pick = int'($urandom_range(0, 99));
      if (pick < 60)      b = 8'($urandom_range(32, 126));
      else if (pick < 72) b = 8'h08;
      else if (pick < 78) b = 8'h7f;
      else if (pick < 88) b = 8'h0d;
      else                b = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 99) < dens), b, ($urandom_range(0, 99) < 60));
    end
    idle(60, 1'b1);
    check("echo_q_empty", echo_q.size(), 0);
    check("line_q_empty", line_q.size(), 0);
    check("drop_q_empty", drop_q.size(), 0);

    send_str("MNO", 3, 1'b0);
    put(8'h0d, 0, 1'b0);
    idle(4, 1'b0);
    check("pre_reset_line_valid", line_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_drain_reset");
    mon_en = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(20, 1'b1);
    check("final_echo_q_empty", echo_q.size(), 0);
    check("final_line_q_empty", line_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
